// File: rtl/pico_mem_arbiter.sv
// Two-master round-robin arbiter in front of one PicoRV32 native memory slave.
// One transaction is locked per grant; a watchdog forces completion on a stalled slave.
module pico_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  m_valid,
    input  logic [1:0]  m_instr,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [7:0]  m_wstrb,
    output logic [1:0]  m_ready,
    output logic [31:0] m_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err,
    output logic        timeout_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            rr_q, rr_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            instr_q, instr_d;
    logic            terr_q, terr_d;
    logic            tid_q, tid_d;

    logic            to_fire;
    logic            done;
    logic            sel;

    // A same-cycle s_ready beats the watchdog, so the timeout requires s_ready low.
    assign to_fire = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) && !s_ready && (wd_q == WD_LAST);
    assign done    = (state_q == BUSY) && (s_ready || to_fire);
    assign sel     = (&m_valid) ? rr_q : m_valid[1];

    assign busy        = (state_q == BUSY);
    assign s_valid     = (state_q == BUSY);
    assign grant       = grant_q;
    assign s_addr      = addr_q;
    assign s_wdata     = wdata_q;
    assign s_wstrb     = wstrb_q;
    assign s_instr     = instr_q;
    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;
    assign m_ready     = done ? {grant_q, ~grant_q} : 2'b00;
    assign m_rdata     = to_fire ? 32'hDEAD_BEEF : s_rdata;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        instr_d = instr_q;
        terr_d  = terr_q;
        tid_d   = tid_q;

        unique case (state_q)
            IDLE: begin
                if (|m_valid) begin
                    state_d = BUSY;
                    grant_d = sel;
                    wd_d    = '0;
                    addr_d  = sel ? m_addr[63:32]  : m_addr[31:0];
                    wdata_d = sel ? m_wdata[63:32] : m_wdata[31:0];
                    wstrb_d = sel ? m_wstrb[7:4]   : m_wstrb[3:0];
                    instr_d = sel ? m_instr[1]     : m_instr[0];
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    rr_d    = ~grant_q;
                    if (to_fire) begin
                        terr_d = 1'b1;
                        if (!terr_q) tid_d = grant_q;
                    end
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            wd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            terr_q  <= 1'b0;
            tid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            terr_q  <= terr_d;
            tid_q   <= tid_d;
        end
    end

endmodule
